preamble_generator: RTL
=======================

// Module: preamble_generator
// PURPOSE
//   Transmit-side counterpart of the autocorrelation detector: on a start pulse, emits the 802.11a training preamble.
//   Output is the short training field (STF): a 16-sample period repeated STF_REPEATS times, followed by the long training field (LTF).
//   Complex samples stream out on a valid/ready master port into the TX sample path.
//   A receiver autocorrelating at DELAY=16 sees a plateau over the STF.
// PARAMETERS
//   WIDTH        16  bits per real/imag component at output; legal 8..16
//   STF_REPEATS  10  number of 16-sample STF periods; legal 1..15
// PORTS
//   clk      in   1        single clock; all logic rising-edge
//   reset    in   1        synchronous, active-high
//   start    in   1        one-cycle request to emit one preamble; sampled only in IDLE
//   busy     out  1        high from cycle after accepted start until final beat accepted
//   m_valid  out  1        output sample valid
//   m_ready  in   1        downstream accepts when m_valid && m_ready
//   m_data   out  2*WIDTH  complex sample {real[2*WIDTH-1:WIDTH], imag[WIDTH-1:0]}, two's complement
//   m_last   out  1        high with the final sample of the preamble
// BEHAVIOUR
//   Reset: state=IDLE; m_valid=0, m_last=0, m_data=0, busy=0; counters cleared.
//   Reset mid-frame aborts immediately; no m_last is emitted; next start begins at STF sample 0.
//   States: IDLE -> STF -> (LTF_GI -> LTF_SYM, if PREAMBLE_LTF_EN) -> IDLE.
//   IDLE: start=1 -> STF; first sample valid on the following cycle (latency 1, registered output).
//   STF: idx 0..15 over STF_TABLE, rep 0..STF_REPEATS-1; each accepted beat advances idx; idx wrap increments rep.
//   LTF_GI: 32 samples, LTF_TABLE[32..63]. LTF_SYM: LTF_TABLE[0..63] twice.
//   Handshake: counters/state advance only on m_valid && m_ready.
//   m_data/m_last are held stable while m_valid && !m_ready; m_valid never drops without a handshake.
//   Output is gap-free when m_ready is held high: one sample per cycle.
//   m_last=1 only on the final sample of the preamble: STF (rep=STF_REPEATS-1, idx=15) or LTF_SYM (second pass, idx 63).
//   On the m_last handshake: next cycle m_valid=0, busy=0, state=IDLE.
//   A start asserted in that IDLE cycle launches the next preamble, so the back-to-back gap is exactly 1 cycle.
//   start while busy is ignored; it is not queued.
//   Width: tables are signed Q1.15, 16 bits. Output = table[15 -: WIDTH] (truncation toward -inf), no rounding.
//   Sample count: 16*STF_REPEATS, plus 160 with PREAMBLE_LTF_EN.
// CONFIGURATION
//   PREAMBLE_LTF_EN defined: STF followed by LTF_GI and LTF_SYM; with defaults, 320 samples.
//   Undefined: STF only; m_last on final STF sample; LTF table and states not synthesised; 160 samples with defaults.
// STRUCTURE
//   preamble_pkg holds the following:
//     STF_LEN=16, LTF_LEN=64, LTF_GI_LEN=32
//     STF_TABLE[16] and LTF_TABLE[64] as signed 16-bit {re,im} Q1.15, scaled x4 from the standard's time-domain values
//     state enum preamble_state_t {IDLE, STF, LTF_GI, LTF_SYM}
//   One sub-module: preamble_rom. It takes a table select and a 6-bit index and returns the 32-bit table word combinationally.
//   The output register lives in preamble_generator.
// TESTING
//   1. Reset, m_ready=1, start pulse at cycle 5:
//      -> m_valid rises at cycle 6; m_data==STF_TABLE[0] (re=6029, im=6029 at WIDTH=16); busy=1.
//   2. STF only, m_ready=1:
//      -> exactly 160 beats; beat k == beat k+16 for all k<144; m_last only on beat 159; busy drops the cycle after.
//   3. Random m_ready backpressure at ~50% duty:
//      -> m_data/m_last stable while stalled; accepted sequence identical to test 2; no lost or duplicated beats.
//   4. With PREAMBLE_LTF_EN:
//      -> 320 beats; beat 160 == LTF_TABLE[32]; beat 192 == LTF_TABLE[0]; beats 192..255 == 256..319; m_last on 319.
//   5. start re-pulsed at beat 50; reset asserted at beat 80:
//      -> the beat-50 start is ignored; after reset m_valid=0, busy=0; the next start restarts at STF_TABLE[0].
//   6. WIDTH=12, looped into autocorrelation (DELAY=16, LENGTH=16):
//      -> outputs are table>>>4; |autocorr| is within 1 LSB of constant over STF beats 32..159.

Source files
------------

// File: rtl/preamble_pkg.sv
// Shared types and training-field tables for the 802.11a preamble generator.
// The LTF table exists only when PREAMBLE_LTF_EN is defined.
package preamble_pkg;

    localparam int STF_LEN    = 16;
    localparam int LTF_LEN    = 64;
    localparam int LTF_GI_LEN = 32;

    typedef enum logic [1:0] {
        IDLE,
        STF,
        LTF_GI,
        LTF_SYM
    } preamble_state_t;

    typedef enum logic {
        TBL_STF,
        TBL_LTF
    } table_sel_t;

    // Inputs are the standard's time-domain samples in thousandths; x4 scaled into Q1.15, rounded to nearest.
    function automatic logic [15:0] q15x4(input int milli);
        int scaled;
        scaled = milli * 131072;
        scaled = (scaled >= 0) ? (scaled + 500) / 1000 : (scaled - 500) / 1000;
        return scaled[15:0];
    endfunction

    function automatic logic [31:0] cpx(input int re_milli, input int im_milli);
        return {q15x4(re_milli), q15x4(im_milli)};
    endfunction

    localparam logic [31:0] STF_TABLE [STF_LEN] = '{
        cpx(  46,   46), cpx(-132,    2), cpx( -13,  -79), cpx( 143,  -13),
        cpx(  92,    0), cpx( 143,  -13), cpx( -13,  -79), cpx(-132,    2),
        cpx(  46,   46), cpx(   2, -132), cpx( -79,  -13), cpx( -13,  143),
        cpx(   0,   92), cpx( -13,  143), cpx( -79,  -13), cpx(   2, -132)
    };

`ifdef PREAMBLE_LTF_EN
    localparam logic [31:0] LTF_TABLE [LTF_LEN] = '{
        cpx( 156,    0), cpx(  -5, -120), cpx(  40, -111), cpx(  97,   83),
        cpx(  21,   28), cpx(  60,  -88), cpx(-115,  -55), cpx( -38, -106),
        cpx(  98,  -26), cpx(  53,    4), cpx(   1, -115), cpx(-137,  -47),
        cpx(  24,  -59), cpx(  59,  -15), cpx( -22,  161), cpx( 119,   -4),
        cpx(  62,  -62), cpx(  37,   98), cpx( -57,   39), cpx(-131,   65),
        cpx(  82,   92), cpx(  70,   14), cpx( -60,   81), cpx( -56,  -22),
        cpx( -35, -151), cpx(-122,  -17), cpx(-127,  -21), cpx(  75,  -74),
        cpx(  -3,   54), cpx( -92,  115), cpx(  92,  106), cpx(  12,   98),
        cpx(-156,    0), cpx(  12,  -98), cpx(  92, -106), cpx( -92, -115),
        cpx(  -3,  -54), cpx(  75,   74), cpx(-127,   21), cpx(-122,   17),
        cpx( -35,  151), cpx( -56,   22), cpx( -60,  -81), cpx(  70,  -14),
        cpx(  82,  -92), cpx(-131,  -65), cpx( -57,  -39), cpx(  37,  -98),
        cpx(  62,   62), cpx( 119,    4), cpx( -22, -161), cpx(  59,   15),
        cpx(  24,   59), cpx(-137,   47), cpx(   1,  115), cpx(  53,   -4),
        cpx(  98,   26), cpx( -38,  106), cpx(-115,   55), cpx(  60,   88),
        cpx(  21,  -28), cpx(  97,  -83), cpx(  40,  111), cpx(  -5,  120)
    };
`endif

endpackage

// File: rtl/preamble_rom.sv
// Combinational lookup into the STF/LTF training tables.
// The LTF branch is present only when PREAMBLE_LTF_EN is defined.
module preamble_rom
    import preamble_pkg::*;
(
    input  table_sel_t  sel,
    input  logic [5:0]  idx,
    output logic [31:0] word
);

    // NOTE: the tables are constants, so there is no storage here to reset.
    always_comb begin
        word = '0;
        if (sel == TBL_STF) begin
            if (idx[5:4] == 2'b00) begin
                word = STF_TABLE[idx[3:0]];
            end
        end
`ifdef PREAMBLE_LTF_EN
        else begin
            word = LTF_TABLE[idx];
        end
`endif
    end

endmodule

// File: rtl/preamble_generator.sv
// 802.11a training preamble source on a valid/ready master port; STF only by default,
// STF followed by LTF guard interval and two LTF symbols when PREAMBLE_LTF_EN is defined.
module preamble_generator
    import preamble_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int STF_REPEATS = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic               busy,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [2*WIDTH-1:0] m_data,
    output logic               m_last
);

    localparam logic [3:0] REP_LAST     = 4'(STF_REPEATS - 1);
    localparam logic [5:0] STF_IDX_LAST = 6'(STF_LEN - 1);
`ifdef PREAMBLE_LTF_EN
    localparam logic [5:0] LTF_IDX_LAST = 6'(LTF_LEN - 1);
    localparam logic [5:0] LTF_GI_FIRST = 6'(LTF_LEN - LTF_GI_LEN);
`endif

    preamble_state_t    state_q, state_d, adv_state;
    logic [5:0]         idx_q, idx_d, adv_idx;
    logic [3:0]         rep_q, rep_d, adv_rep;
`ifdef PREAMBLE_LTF_EN
    logic               pass_q, pass_d, adv_pass;
`endif
    logic               valid_q, valid_d;
    logic               last_q, last_d, adv_last;
    logic [2*WIDTH-1:0] data_q, data_d;
    logic               adv_done, fire, load;
    table_sel_t         rom_sel;
    logic [31:0]        rom_word;

    // The state/counters name the sample currently presented; adv_* is the sample after it.
    always_comb begin
        // NOTE: every signal gets a default first so no path through the block can infer a latch.
        adv_state = state_q;
        adv_idx   = idx_q + 6'd1;
        adv_rep   = rep_q;
        adv_done  = 1'b0;
`ifdef PREAMBLE_LTF_EN
        adv_pass  = pass_q;
`endif
        case (state_q)
            IDLE: begin
                adv_state = STF;
                adv_idx   = '0;
                adv_rep   = '0;
`ifdef PREAMBLE_LTF_EN
                adv_pass  = 1'b0;
`endif
            end
            STF: begin
                if (idx_q == STF_IDX_LAST) begin
                    adv_idx = '0;
                    if (rep_q == REP_LAST) begin
`ifdef PREAMBLE_LTF_EN
                        adv_state = LTF_GI;
                        adv_idx   = LTF_GI_FIRST;
`else
                        adv_done  = 1'b1;
`endif
                    end else begin
                        adv_rep = rep_q + 4'd1;
                    end
                end
            end
`ifdef PREAMBLE_LTF_EN
            LTF_GI: begin
                if (idx_q == LTF_IDX_LAST) begin
                    adv_state = LTF_SYM;
                    adv_idx   = '0;
                end
            end
            LTF_SYM: begin
                if (idx_q == LTF_IDX_LAST) begin
                    if (pass_q) begin
                        adv_done = 1'b1;
                    end else begin
                        adv_pass = 1'b1;
                        adv_idx  = '0;
                    end
                end
            end
`endif
            default: ;
        endcase
    end

`ifdef PREAMBLE_LTF_EN
    assign adv_last = (adv_state == LTF_SYM) && adv_pass && (adv_idx == LTF_IDX_LAST);
`else
    assign adv_last = (adv_state == STF) && (adv_rep == REP_LAST) && (adv_idx == STF_IDX_LAST);
`endif

    assign rom_sel = (adv_state == STF) ? TBL_STF : TBL_LTF;

    preamble_rom u_rom (
        .sel  (rom_sel),
        .idx  (adv_idx),
        .word (rom_word)
    );

    always_comb begin
        fire    = valid_q && m_ready;
        load    = (state_q == IDLE) ? start : (fire && !adv_done);
        state_d = state_q;
        idx_d   = idx_q;
        rep_d   = rep_q;
`ifdef PREAMBLE_LTF_EN
        pass_d  = pass_q;
`endif
        valid_d = valid_q;
        last_d  = last_q;
        data_d  = data_q;
        if (load) begin
            state_d = adv_state;
            idx_d   = adv_idx;
            rep_d   = adv_rep;
`ifdef PREAMBLE_LTF_EN
            pass_d  = adv_pass;
`endif
            valid_d = 1'b1;
            last_d  = adv_last;
            // Keep the top WIDTH bits of each component: truncation toward -inf.
            data_d  = {rom_word[31 -: WIDTH], rom_word[15 -: WIDTH]};
        end else if (fire && adv_done) begin
            state_d = IDLE;
            idx_d   = '0;
            rep_d   = '0;
`ifdef PREAMBLE_LTF_EN
            pass_d  = 1'b0;
`endif
            valid_d = 1'b0;
            last_d  = 1'b0;
            data_d  = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            rep_q   <= '0;
`ifdef PREAMBLE_LTF_EN
            pass_q  <= 1'b0;
`endif
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            rep_q   <= rep_d;
`ifdef PREAMBLE_LTF_EN
            pass_q  <= pass_d;
`endif
            valid_q <= valid_d;
            last_q  <= last_d;
            data_q  <= data_d;
        end
    end

    assign busy    = (state_q != IDLE);
    assign m_valid = valid_q;
    assign m_data  = data_q;
    assign m_last  = last_q;

endmodule
